// File: rtl/bcd_digit_entry_if.sv
// Keypad-side and downstream-side signals of the BCD digit entry block.
// The master modport is the environment (keys, commands, consumer ready);
// the slave modport is the entry block itself.
interface bcd_digit_entry_if #(
  parameter int NUM_DIGITS = 4
) ();
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [9:0]              key_in;
  logic                    enter;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [CW-1:0]           digit_count;
  logic                    digit_strobe;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_multi;
  logic                    err_overflow;

  modport master (
    output key_in, enter, clear, out_ready,
    input  digits_out, digit_count, digit_strobe, out_valid, err_multi, err_overflow
  );

  modport slave (
    input  key_in, enter, clear, out_ready,
    output digits_out, digit_count, digit_strobe, out_valid, err_multi, err_overflow
  );
endinterface

// File: rtl/bcd_digit_entry.sv
// Debounced one-hot keypad to multi-digit BCD entry register.
// Each validated key press shifts one BCD digit into the register; 'enter'
// presents the number downstream with a valid/ready handshake.
// NUM_DIGITS and STABLE_CYCLES must both be at least 1.
module bcd_digit_entry #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  bcd_digit_entry_if.slave bus
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_PRESENT  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [9:0]    key_q, key_d;
  logic          armed_q, armed_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [DW-1:0] digits_q, digits_d;
  logic [CW-1:0] count_q, count_d;
  logic          strobe_q, strobe_d;
  logic          valid_q, valid_d;
  logic          err_multi_q, err_multi_d;
  logic          err_ovf_q, err_ovf_d;

  logic [3:0]    enc;
  logic [DW-1:0] shifted;
  logic          key_busy;
  logic          settled;
  logic          is_onehot;

  // Sample register and stability counter. After reset, sampling stays
  // gated off until the keys have been seen released once, so a key held
  // through reset is never accepted.
  always_comb begin
    armed_d = armed_q | (bus.key_in == 10'd0);
    key_d   = armed_q ? bus.key_in : 10'd0;
    stab_d  = stab_q;
    if (key_d == 10'd0) begin
      stab_d = '0;
    end else if (key_d != key_q) begin
      stab_d = SW'(1);
    end else if (stab_q != SW'(STABLE_CYCLES)) begin
      stab_d = stab_q + SW'(1);
    end
  end

  // One-hot to BCD: OR of the indices of set bits (exact when one-hot).
  always_comb begin
    enc = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (key_q[k]) begin
        enc = enc | 4'(k);
      end
    end
  end

  // Newest digit enters nibble 0; a single-digit register is simply replaced.
  generate
    if (NUM_DIGITS == 1) begin : g_one_digit
      assign shifted = enc;
    end else begin : g_multi_digit
      assign shifted = {digits_q[DW-5:0], enc};
    end
  endgenerate

  assign key_busy  = (key_q != 10'd0);
  assign settled   = key_busy && (stab_q == SW'(STABLE_CYCLES));
  assign is_onehot = $onehot(key_q);

  // Entry FSM: clear > enter > debounce completion; PRESENT ignores keys.
  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    count_d     = count_q;
    strobe_d    = 1'b0;
    err_multi_d = 1'b0;
    err_ovf_d   = 1'b0;

    if (bus.clear) begin
      digits_d = '0;
      count_d  = '0;
      state_d  = key_busy ? S_HELD : S_IDLE;
    end else if (state_q == S_PRESENT) begin
      if (bus.out_ready) begin
        digits_d = '0;
        count_d  = '0;
        state_d  = key_busy ? S_HELD : S_IDLE;
      end
    end else if (bus.enter && (count_q != '0)) begin
      // Any debounce in progress is abandoned.
      state_d = S_PRESENT;
    end else begin
      case (state_q)
        S_IDLE, S_DEBOUNCE: begin
          if (!key_busy) begin
            state_d = S_IDLE;
          end else if (settled) begin
            state_d = S_HELD;
            if (!is_onehot) begin
              err_multi_d = 1'b1;
            end else if (count_q == CW'(NUM_DIGITS)) begin
              err_ovf_d = 1'b1;
            end else begin
              digits_d = shifted;
              count_d  = count_q + CW'(1);
              strobe_d = 1'b1;
            end
          end else begin
            state_d = S_DEBOUNCE;
          end
        end
        S_HELD: begin
          if (!key_busy) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    valid_d = (state_d == S_PRESENT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      armed_q     <= 1'b0;
      stab_q      <= '0;
      digits_q    <= '0;
      count_q     <= '0;
      strobe_q    <= 1'b0;
      valid_q     <= 1'b0;
      err_multi_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      armed_q     <= armed_d;
      stab_q      <= stab_d;
      digits_q    <= digits_d;
      count_q     <= count_d;
      strobe_q    <= strobe_d;
      valid_q     <= valid_d;
      err_multi_q <= err_multi_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign bus.digits_out   = digits_q;
  assign bus.digit_count  = count_q;
  assign bus.digit_strobe = strobe_q;
  assign bus.out_valid    = valid_q;
  assign bus.err_multi    = err_multi_q;
  assign bus.err_overflow = err_ovf_q;
endmodule
